predictor_chooser: RTL and testbench
====================================

// Module: predictor_chooser
// PURPOSE
//   Downstream stage of PatternPredictor. Consumes the per-bit predictions and match flags of
//   its two sub-predictors (Y, Z) and keeps tournament-style state to pick the better one.
//   Drives one final prediction, plus sliding-window and cumulative accuracy statistics.
//   Sits between the predictor and the lab display/scoreboard logic.
// PARAMETERS
//   WIN    16  sliding-window length in resolved bits; power of two, 2..64
//   CNT_W  8   width of the cumulative counters final_cnt and sel_switches
// PORTS
//   clk           in   1                  rising-edge clock
//   reset         in   1                  asynchronous active-low reset (asserted when 0)
//   valid_in      in   1                  an X bit resolved this cycle; y_*/z_* inputs are valid
//   y_pred        in   1                  Y prediction for the next bit
//   y_match       in   1                  Y's previous prediction matched the resolved X bit
//   z_pred        in   1                  Z prediction for the next bit
//   z_match       in   1                  Z's previous prediction matched the resolved X bit
//   sel           out  1                  current choice: 0 = Y, 1 = Z
//   final_pred    out  1                  sel ? z_pred : y_pred (combinational)
//   final_match   out  1                  registered match flag of the predictor that was chosen
//   final_cnt     out  CNT_W              saturating count of final_match hits
//   sel_switches  out  CNT_W              saturating count of sel changes
//   y_win_hits    out  $clog2(WIN)+1      Y hits within the last WIN events
//   z_win_hits    out  $clog2(WIN)+1      Z hits within the last WIN events
//   win_full      out  1                  WIN events seen since reset
// BEHAVIOUR
// - Reset (reset==0, async): chooser = STRONG_Y, fill = 0, both window shift registers = 0.
//   Every registered output is 0: sel, final_match, final_cnt, sel_switches, *_win_hits, win_full.
// - valid_in==0: no state changes. final_pred still follows sel and the live y_pred/z_pred.
// - Chooser FSM: 2-bit saturating counter.
//   - States: STRONG_Y=00, WEAK_Y=01, WEAK_Z=10, STRONG_Z=11. sel = state[1].
//   - On valid_in:
//     - y_match & !z_match: decrement, saturating at 00.
//     - z_match & !y_match: increment, saturating at 11.
//     - Both hit or both miss: hold.
// - Latency: one cycle. Every update from a valid_in cycle is visible after the next clk edge.
// - final_match: the match flag of the predictor selected by sel *before* this event's chooser
//   update. It is registered and holds its value between events.
// - final_cnt: increments when that flag is 1. It saturates at 2^CNT_W-1 and never wraps.
// - sel_switches: increments when state[1] changes on this event. It saturates and never wraps.
// - Windows: each of y_hist and z_hist is a WIN-bit shift register that takes the new match bit.
//   - Running count update: hits <= hits + new - (fill==WIN ? oldest : 0).
//   - Never recompute the count with a popcount.
//   - When new equals the evicted bit, the count holds.
//   - Range is 0..WIN; the value WIN is legal.
// - fill: counts 0..WIN and stops at WIN. win_full = (fill == WIN).
// - Back-to-back valid_in on consecutive cycles is fully supported; there are no stalls.
// - Reset mid-operation: every state clears immediately; the first valid_in after release counts
//   as event 1.
// CONFIGURATION
// - Macro PREDICTOR_WARMUP_EN:
//   - Defined: the chooser FSM, sel and sel_switches hold until win_full==1. Windows, fill,
//     final_match and final_cnt still update from the first event.
//   - Undefined: the chooser updates from the first valid_in after reset.
// TESTING (WIN=4, CNT_W=3 unless stated)
// 1. Async reset: drop reset mid-cycle with state non-zero -> all outputs 0 and sel=0 at once,
//    without waiting for a clk edge.
// 2. Chooser: events (y,z) = (1,0),(0,1),(0,1),(0,1),(1,0)
//    -> state 00,01,10,11,10; sel 0,0,1,1,1; sel_switches=1.
// 3. Window: y_match 1,1,1,1,0,1 with z_match=0 -> y_win_hits 1,2,3,4,3,3;
//    win_full=1 from the 4th event; z_win_hits stays 0.
// 4. Saturation: 9 events with y_match=1, z_match=0 -> final_cnt=7 and holds; sel stays 0.
// 5. Gaps: valid_in=0 for 5 cycles between events -> no counter or window changes.
//    final_pred still tracks y_pred.
// 6. PREDICTOR_WARMUP_EN defined: 3 events (0,1) -> sel=0, sel_switches=0.
//    4th event (0,1) -> state 01. 5th (0,1) -> sel=1.

Source files
------------

// File: rtl/predictor_chooser.sv
// Tournament chooser between sub-predictors Y and Z, with sliding-window and cumulative accuracy stats.
// Optional macro PREDICTOR_WARMUP_EN: chooser, sel and sel_switches hold until the window is full.
module predictor_chooser #(
    parameter int WIN   = 16,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  y_pred,
    input  logic                  y_match,
    input  logic                  z_pred,
    input  logic                  z_match,
    output logic                  sel,
    output logic                  final_pred,
    output logic                  final_match,
    output logic [CNT_W-1:0]      final_cnt,
    output logic [CNT_W-1:0]      sel_switches,
    output logic [$clog2(WIN):0]  y_win_hits,
    output logic [$clog2(WIN):0]  z_win_hits,
    output logic                  win_full
);
    localparam int HW = $clog2(WIN) + 1;
    localparam logic [HW-1:0]    FILL_MAX = HW'(WIN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        STRONG_Y = 2'b00,
        WEAK_Y   = 2'b01,
        WEAK_Z   = 2'b10,
        STRONG_Z = 2'b11
    } chooser_t;

    chooser_t         r_state, w_state_nxt;
    logic             w_chooser_en;
    logic [HW-1:0]    r_fill, w_fill_nxt;
    logic [WIN-1:0]   r_y_hist, r_z_hist;
    logic [HW-1:0]    r_y_hits, r_z_hits;
    logic             r_final_match;
    logic [CNT_W-1:0] r_final_cnt, r_sel_switches;
    logic             w_fm_new, w_y_evict, w_z_evict, w_switch;

    assign w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + HW'(1);
    assign w_fm_new   = r_state[1] ? z_match : y_match;
    // Before the window is full the top history bits are still zero, but gate on fill anyway.
    assign w_y_evict  = (r_fill == FILL_MAX) & r_y_hist[WIN-1];
    assign w_z_evict  = (r_fill == FILL_MAX) & r_z_hist[WIN-1];
    assign w_switch   = w_state_nxt[1] != r_state[1];

    always_comb begin
        w_state_nxt  = r_state;
`ifdef PREDICTOR_WARMUP_EN
        // The event that fills the window is the first one allowed to train the chooser.
        w_chooser_en = valid_in && (w_fill_nxt == FILL_MAX);
`else
        w_chooser_en = valid_in;
`endif
        if (w_chooser_en) begin
            if (y_match && !z_match) begin
                case (r_state)
                    STRONG_Z: w_state_nxt = WEAK_Z;
                    WEAK_Z:   w_state_nxt = WEAK_Y;
                    default:  w_state_nxt = STRONG_Y;
                endcase
            end else if (z_match && !y_match) begin
                case (r_state)
                    STRONG_Y: w_state_nxt = WEAK_Y;
                    WEAK_Y:   w_state_nxt = WEAK_Z;
                    default:  w_state_nxt = STRONG_Z;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STRONG_Y;
        end else if (valid_in) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill         <= '0;
            r_y_hist       <= '0;
            r_z_hist       <= '0;
            r_y_hits       <= '0;
            r_z_hits       <= '0;
            r_final_match  <= 1'b0;
            r_final_cnt    <= '0;
            r_sel_switches <= '0;
        end else if (valid_in) begin
            r_fill        <= w_fill_nxt;
            r_y_hist      <= {r_y_hist[WIN-2:0], y_match};
            r_z_hist      <= {r_z_hist[WIN-2:0], z_match};
            r_y_hits      <= r_y_hits + HW'(y_match) - HW'(w_y_evict);
            r_z_hits      <= r_z_hits + HW'(z_match) - HW'(w_z_evict);
            r_final_match <= w_fm_new;
            if (w_fm_new && (r_final_cnt != CNT_MAX))
                r_final_cnt <= r_final_cnt + CNT_W'(1);
            if (w_switch && (r_sel_switches != CNT_MAX))
                r_sel_switches <= r_sel_switches + CNT_W'(1);
        end
    end

    assign sel          = r_state[1];
    assign final_pred   = r_state[1] ? z_pred : y_pred;
    assign final_match  = r_final_match;
    assign final_cnt    = r_final_cnt;
    assign sel_switches = r_sel_switches;
    assign y_win_hits   = r_y_hits;
    assign z_win_hits   = r_z_hits;
    assign win_full     = (r_fill == FILL_MAX);
endmodule

// File: tb/tb_predictor_chooser.sv
// Randomized self-checking bench for predictor_chooser against a queue-based accuracy model.
module tb_predictor_chooser;
    localparam int WIN   = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             valid_in = 1'b0;
    logic             y_pred = 1'b0, y_match = 1'b0, z_pred = 1'b0, z_match = 1'b0;
    logic             sel, final_pred, final_match, win_full;
    logic [CNT_W-1:0] final_cnt, sel_switches;
    logic [2:0]       y_win_hits, z_win_hits;

    int n_chk = 0;
    int n_fail = 0;

    // Model: chooser as an integer 0..3, windows as queues of the last WIN match bits.
    int m_ch, m_fcnt, m_sw, m_n;
    bit m_fm;
    bit yq[$];
    bit zq[$];

    predictor_chooser #(.WIN(WIN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .y_pred(y_pred), .y_match(y_match), .z_pred(z_pred), .z_match(z_match),
        .sel(sel), .final_pred(final_pred), .final_match(final_match),
        .final_cnt(final_cnt), .sel_switches(sel_switches),
        .y_win_hits(y_win_hits), .z_win_hits(z_win_hits), .win_full(win_full)
    );

    always #5 clk = ~clk;

    function automatic int qsum(input bit q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    task automatic m_clear();
        m_ch = 0; m_fcnt = 0; m_sw = 0; m_n = 0; m_fm = 0;
        yq.delete(); zq.delete();
    endtask

    task automatic m_apply(input bit ym, input bit zm);
        bit pre, warm;
        pre  = (m_ch >= 2);
        m_fm = pre ? zm : ym;
        if (m_fm && m_fcnt < CMAX) m_fcnt++;
        yq.push_back(ym);
        zq.push_back(zm);
        if (yq.size() > WIN) begin
            void'(yq.pop_front());
            void'(zq.pop_front());
        end
        if (m_n < WIN) m_n++;
        warm = 1'b1;
`ifdef PREDICTOR_WARMUP_EN
        warm = (m_n >= WIN);
`endif
        if (warm) begin
            if (ym && !zm && m_ch > 0) m_ch--;
            else if (zm && !ym && m_ch < 3) m_ch++;
        end
        if (((m_ch >= 2) != pre) && m_sw < CMAX) m_sw++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; valid_in = 1'b0;
        m_clear();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic step(input bit v, input bit ym, input bit zm, input bit yp, input bit zp);
        valid_in = v; y_match = ym; z_match = zm; y_pred = yp; z_pred = zp;
        @(posedge clk); #1;
        if (v) m_apply(ym, zm);
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if ({sel, final_match, final_cnt, sel_switches, y_win_hits, z_win_hits, win_full} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sel=%b fm=%b fcnt=%0d sw=%0d yh=%0d zh=%0d full=%b, want all 0",
                     sel, final_match, final_cnt, sel_switches, y_win_hits, z_win_hits, win_full);
        end
        do_reset();
    endtask

    task automatic test_chooser();
        bit ys[5] = '{1, 0, 0, 0, 1};
        bit zs[5] = '{0, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ys[i], zs[i], 1'b0, 1'b1);
            n_chk++;
            if (sel !== (m_ch >= 2)) begin
                n_fail++;
                $display("FAIL chooser_sel[%0d]: got %b want %b", i, sel, (m_ch >= 2));
            end
            n_chk++;
            if (final_match !== m_fm) begin
                n_fail++;
                $display("FAIL chooser_final_match[%0d]: got %b want %b", i, final_match, m_fm);
            end
        end
`ifndef PREDICTOR_WARMUP_EN
        n_chk++;
        if (sel_switches !== 3'd1 || sel !== 1'b1) begin
            n_fail++;
            $display("FAIL chooser_switches: got sw=%0d sel=%b want sw=1 sel=1", sel_switches, sel);
        end
`endif
        n_chk++;
        if (sel_switches !== CNT_W'(m_sw)) begin
            n_fail++;
            $display("FAIL chooser_switch_model: got %0d want %0d", sel_switches, m_sw);
        end
    endtask

    task automatic test_window();
        bit ys[6] = '{1, 1, 1, 1, 0, 1};
        int eh[6] = '{1, 2, 3, 4, 3, 3};
        bit ef[6] = '{0, 0, 0, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ys[i], 1'b0, 1'b0, 1'b0);
            n_chk++;
            if (y_win_hits !== 3'(eh[i]) || win_full !== ef[i] || z_win_hits !== 3'd0) begin
                n_fail++;
                $display("FAIL window[%0d]: got yh=%0d full=%b zh=%0d want yh=%0d full=%b zh=0",
                         i, y_win_hits, win_full, z_win_hits, eh[i], ef[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (final_cnt !== 3'd7 || sel !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation: got fcnt=%0d sel=%b want fcnt=7 sel=0", final_cnt, sel);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (final_cnt !== 3'd7 || y_win_hits !== 3'd4) begin
            n_fail++;
            $display("FAIL saturation_hold: got fcnt=%0d yh=%0d want fcnt=7 yh=4", final_cnt, y_win_hits);
        end
    endtask

    task automatic test_gaps();
        logic [CNT_W-1:0] fc, sw;
        logic [2:0]       yh, zh;
        logic             s, fm, wf;
        bit               yp;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        {fc, sw, yh, zh, s, fm, wf} = {final_cnt, sel_switches, y_win_hits, z_win_hits, sel, final_match, win_full};
        for (int i = 0; i < 5; i++) begin
            yp = 1'($urandom);
            step(1'b0, 1'($urandom), 1'($urandom), yp, 1'($urandom));
            n_chk++;
            if ({final_cnt, sel_switches, y_win_hits, z_win_hits, sel, final_match, win_full} !==
                {fc, sw, yh, zh, s, fm, wf}) begin
                n_fail++;
                $display("FAIL gap_hold[%0d]: got fcnt=%0d sw=%0d yh=%0d zh=%0d want fcnt=%0d sw=%0d yh=%0d zh=%0d",
                         i, final_cnt, sel_switches, y_win_hits, z_win_hits, fc, sw, yh, zh);
            end
            n_chk++;
            if (final_pred !== yp) begin
                n_fail++;
                $display("FAIL gap_final_pred[%0d]: got %b want %b", i, final_pred, yp);
            end
        end
    endtask

    task automatic test_warmup();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            n_chk++;
            if (sel !== (m_ch >= 2) || sel_switches !== CNT_W'(m_sw)) begin
                n_fail++;
                $display("FAIL warmup[%0d]: got sel=%b sw=%0d want sel=%b sw=%0d",
                         i, sel, sel_switches, (m_ch >= 2), m_sw);
            end
`ifdef PREDICTOR_WARMUP_EN
            if (i == 2) begin
                n_chk++;
                if (sel !== 1'b0 || sel_switches !== 3'd0) begin
                    n_fail++;
                    $display("FAIL warmup_hold: got sel=%b sw=%0d want sel=0 sw=0", sel, sel_switches);
                end
            end
            if (i == 4) begin
                n_chk++;
                if (sel !== 1'b1) begin
                    n_fail++;
                    $display("FAIL warmup_fifth: got sel=%b want 1", sel);
                end
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        bit v, ym, zm, yp, zp;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 9) < 8);
            ym = 1'($urandom); zm = 1'($urandom);
            yp = 1'($urandom); zp = 1'($urandom);
            step(v, ym, zm, yp, zp);
            n_chk++;
            if (sel !== (m_ch >= 2) || final_match !== m_fm) begin
                n_fail++;
                $display("FAIL rand_sel_fm[%0d]: got sel=%b fm=%b want sel=%b fm=%b",
                         i, sel, final_match, (m_ch >= 2), m_fm);
            end
            n_chk++;
            if (final_cnt !== CNT_W'(m_fcnt) || sel_switches !== CNT_W'(m_sw)) begin
                n_fail++;
                $display("FAIL rand_counts[%0d]: got fcnt=%0d sw=%0d want fcnt=%0d sw=%0d",
                         i, final_cnt, sel_switches, m_fcnt, m_sw);
            end
            n_chk++;
            if (y_win_hits !== 3'(qsum(yq)) || z_win_hits !== 3'(qsum(zq)) || win_full !== (m_n == WIN)) begin
                n_fail++;
                $display("FAIL rand_window[%0d]: got yh=%0d zh=%0d full=%b want yh=%0d zh=%0d full=%b",
                         i, y_win_hits, z_win_hits, win_full, qsum(yq), qsum(zq), (m_n == WIN));
            end
            n_chk++;
            if (final_pred !== ((m_ch >= 2) ? zp : yp)) begin
                n_fail++;
                $display("FAIL rand_final_pred[%0d]: got %b want %b", i, final_pred, ((m_ch >= 2) ? zp : yp));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        valid_in = 1'b0;
        n_chk++;
        if (sel !== (m_ch >= 2) || y_win_hits !== 3'(qsum(yq)) || z_win_hits !== 3'(qsum(zq))) begin
            n_fail++;
            $display("FAIL async_pre: got sel=%b zh=%0d want sel=%b zh=%0d", sel, z_win_hits, (m_ch >= 2), qsum(zq));
        end
        #3;
        reset = 1'b0;
        #1;
        n_chk++;
        if ({sel, final_match, final_cnt, sel_switches, y_win_hits, z_win_hits, win_full} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got sel=%b fm=%b fcnt=%0d sw=%0d yh=%0d zh=%0d full=%b, want all 0",
                     sel, final_match, final_cnt, sel_switches, y_win_hits, z_win_hits, win_full);
        end
        m_clear();
        @(posedge clk); #1;
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_chk++;
        if (y_win_hits !== 3'd1 || z_win_hits !== 3'd1 || final_cnt !== 3'd1 || win_full !== 1'b0) begin
            n_fail++;
            $display("FAIL async_first_event: got yh=%0d zh=%0d fcnt=%0d full=%b want 1 1 1 0",
                     y_win_hits, z_win_hits, final_cnt, win_full);
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_chooser();
        test_window();
        test_saturation();
        test_gaps();
        test_warmup();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
